// File: rtl/uart_prog_loader.sv
// UART program loader: receives an 8N1 framed image, writes it word by word into
// instruction memory and releases the CPU from reset once the checksum verifies.
module uart_prog_loader #(
  parameter int CLKS_PER_BIT = 217,
  parameter int ADDR_W       = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_a_o,
  output logic [31:0]       imem_d_o,
  output logic              cpu_rst_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [16:0]   MAX_WORDS = 17'(2 ** ADDR_W);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {WAIT_SYNC, LEN_LO, LEN_HI, DATA, CSUM, RUN} ld_state_t;

  rx_state_t         rx_state_q, rx_state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              byte_valid_q, byte_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              rx_meta_q, rx_sync_q, rx_prev_q;

  ld_state_t         ld_q, ld_d;
  logic [15:0]       len_q, len_d;
  logic [16:0]       idx_q, idx_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [23:0]       asm_q, asm_d;
  logic [7:0]        csum_q, csum_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [31:0]       dat_q, dat_d;

  // Receiver: edge-triggered start, mid-bit sampling, stop bit decides valid vs framing error.
  always_comb begin
    rx_state_d   = rx_state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d      = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          rx_state_d = RX_IDLE;
          if (rx_sync_q) byte_valid_d = 1'b1;
          else           frame_err_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Loader: shift_q holds the received byte while byte_valid_q is high.
  always_comb begin
    ld_d   = ld_q;
    len_d  = len_q;
    idx_d  = idx_q;
    bcnt_d = bcnt_q;
    asm_d  = asm_q;
    csum_d = csum_q;
    err_d  = err_q;
    we_d   = 1'b0;
    done_d = 1'b0;
    a_d    = a_q;
    dat_d  = dat_q;
    if (frame_err_q && ld_q != RUN) begin
      err_d = 1'b1;
      ld_d  = WAIT_SYNC;
    end else if (byte_valid_q) begin
      case (ld_q)
        WAIT_SYNC, RUN: begin
          if (shift_q == 8'hA5) begin
            ld_d   = LEN_LO;
            err_d  = 1'b0;
            csum_d = '0;
            idx_d  = '0;
            bcnt_d = '0;
          end
        end
        LEN_LO: begin
          len_d[7:0] = shift_q;
          ld_d       = LEN_HI;
        end
        LEN_HI: begin
          len_d = {shift_q, len_q[7:0]};
          if ({1'b0, shift_q, len_q[7:0]} > MAX_WORDS) begin
            err_d = 1'b1;
            ld_d  = WAIT_SYNC;
          end else if ({shift_q, len_q[7:0]} == 16'd0) begin
            ld_d = CSUM;
          end else begin
            ld_d = DATA;
          end
        end
        DATA: begin
          csum_d = csum_q ^ shift_q;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            we_d  = 1'b1;
            a_d   = idx_q[ADDR_W-1:0];
            dat_d = {shift_q, asm_q};
            idx_d = idx_q + 17'd1;
            if (idx_q + 17'd1 == {1'b0, len_q}) ld_d = CSUM;
          end else begin
            asm_d = {shift_q, asm_q[23:8]};
          end
        end
        CSUM: begin
          if (shift_q == csum_q) begin
            ld_d   = RUN;
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
            ld_d  = WAIT_SYNC;
          end
        end
        default: ld_d = WAIT_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      ld_q         <= WAIT_SYNC;
      len_q        <= '0;
      idx_q        <= '0;
      bcnt_q       <= '0;
      asm_q        <= '0;
      csum_q       <= '0;
      err_q        <= 1'b0;
      we_q         <= 1'b0;
      done_q       <= 1'b0;
      a_q          <= '0;
      dat_q        <= '0;
    end else begin
      rx_meta_q    <= uart_rx_i;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
      rx_state_q   <= rx_state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      ld_q         <= ld_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      bcnt_q       <= bcnt_d;
      asm_q        <= asm_d;
      csum_q       <= csum_d;
      err_q        <= err_d;
      we_q         <= we_d;
      done_q       <= done_d;
      a_q          <= a_d;
      dat_q        <= dat_d;
    end
  end

  assign imem_we_o = we_q;
  assign imem_a_o  = a_q;
  assign imem_d_o  = dat_q;
  assign cpu_rst_o = (ld_q != RUN);
  assign busy_o    = (ld_q == LEN_LO) || (ld_q == LEN_HI) || (ld_q == DATA) || (ld_q == CSUM);
  assign done_o    = done_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader: serial frames in, memory writes checked
// against an expected {addr, data} queue, status outputs checked after each step.
module tb_uart_prog_loader;

  localparam int CPB = 16;
  localparam int AW  = 14;

  logic          clk;
  logic          rst;
  logic          rx;
  logic          imem_we;
  logic [AW-1:0] imem_a;
  logic [31:0]   imem_d;
  logic          cpu_rst;
  logic          busy;
  logic          done;
  logic          err;

  int checks;
  int errors;
  int wr_cnt;
  int done_cnt;

  logic [AW+31:0] exp_q[$];
  logic [AW+31:0] exp_e;
  logic [7:0]     tx_q[$];

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rx_i (rx),
    .imem_we_o (imem_we),
    .imem_a_o  (imem_a),
    .imem_d_o  (imem_d),
    .cpu_rst_o (cpu_rst),
    .busy_o    (busy),
    .done_o    (done),
    .err_o     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_all();
    while (tx_q.size() > 0) send_byte(tx_q.pop_front(), 1'b1);
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic good_frame();
    exp_q.push_back({14'd0, 32'h00100513});
    exp_q.push_back({14'd1, 32'h00200593});
    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
             8'h93, 8'h05, 8'h20, 8'h00, 8'hB0};
    send_all();
  endtask

  // Scoreboard: every write pops one expected {addr, data}; done must coincide with cpu release.
  always @(negedge clk) begin
    if (!rst) begin
      if (imem_we) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          check("we_unexpected", imem_we, 1'b0);
        end else begin
          exp_e = exp_q.pop_front();
          check("we_addr", imem_a, exp_e[AW+31:32]);
          check("we_data", imem_d, exp_e[31:0]);
        end
      end
      if (done) begin
        done_cnt++;
        check("cpu_rst_at_done", cpu_rst, 1'b0);
      end
    end
  end

  initial begin
    checks = 0; errors = 0; wr_cnt = 0; done_cnt = 0;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_rst", cpu_rst, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_we", imem_we, 1'b0);
    check("rst_addr", imem_a, '0);
    check("rst_data", imem_d, '0);
    @(negedge clk);
    rst = 1'b0;

    repeat (1000) @(posedge clk);
    #1;
    check("idle_cpu_rst", cpu_rst, 1'b1);
    check("idle_busy", busy, 1'b0);
    check("idle_err", err, 1'b0);
    check("idle_writes", wr_cnt, 0);

    // Short low pulse: rejected at the mid-start recheck without an error.
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    settle();
    check("glitch_busy", busy, 1'b0);
    check("glitch_err", err, 1'b0);

    send_byte(8'h00, 1'b1);
    send_byte(8'h5A, 1'b1);
    settle();
    check("garbage_busy", busy, 1'b0);

    good_frame();
    settle();
    check("good_writes", wr_cnt, 2);
    check("good_done", done_cnt, 1);
    check("good_cpu_rst", cpu_rst, 1'b0);
    check("good_err", err, 1'b0);
    check("good_busy", busy, 1'b0);
    check("good_queue", exp_q.size(), 0);

    // Bad checksum, launched from RUN.
    exp_q.push_back({14'd0, 32'h00100513});
    exp_q.push_back({14'd1, 32'h00200593});
    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
             8'h93, 8'h05, 8'h20, 8'h00, 8'hB1};
    send_all();
    settle();
    check("badcs_writes", wr_cnt, 4);
    check("badcs_err", err, 1'b1);
    check("badcs_cpu_rst", cpu_rst, 1'b1);
    check("badcs_done", done_cnt, 1);
    check("badcs_busy", busy, 1'b0);

    exp_q.push_back({14'd0, 32'h00100513});
    exp_q.push_back({14'd1, 32'h00200593});
    send_byte(8'hA5, 1'b1);
    settle();
    check("resync_err_clr", err, 1'b0);
    check("resync_busy", busy, 1'b1);
    tx_q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
             8'h93, 8'h05, 8'h20, 8'h00, 8'hB0};
    send_all();
    settle();
    check("reload_done", done_cnt, 2);
    check("reload_writes", wr_cnt, 6);
    check("reload_cpu_rst", cpu_rst, 1'b0);
    check("reload_err", err, 1'b0);

    // Sync from RUN re-asserts cpu reset, then a framing error on data byte 3.
    send_byte(8'hA5, 1'b1);
    settle();
    check("run_sync_cpu_rst", cpu_rst, 1'b1);
    check("run_sync_busy", busy, 1'b1);
    tx_q = '{8'h02, 8'h00, 8'h13, 8'h05};
    send_all();
    send_byte(8'h10, 1'b0);
    settle();
    check("ferr_err", err, 1'b1);
    check("ferr_busy", busy, 1'b0);
    check("ferr_writes", wr_cnt, 6);
    check("ferr_cpu_rst", cpu_rst, 1'b1);

    good_frame();
    settle();
    check("after_ferr_writes", wr_cnt, 8);
    check("after_ferr_done", done_cnt, 3);
    check("after_ferr_cpu_rst", cpu_rst, 1'b0);
    check("after_ferr_err", err, 1'b0);

    tx_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_all();
    settle();
    check("zero_done", done_cnt, 4);
    check("zero_writes", wr_cnt, 8);
    check("zero_cpu_rst", cpu_rst, 1'b0);

    tx_q = '{8'hA5, 8'h01, 8'h40};
    send_all();
    settle();
    check("oversize_err", err, 1'b1);
    check("oversize_busy", busy, 1'b0);
    check("oversize_cpu_rst", cpu_rst, 1'b1);
    check("oversize_writes", wr_cnt, 8);

    // N exactly 2^ADDR_W is legal; then reset after two bytes of word 0.
    tx_q = '{8'hA5, 8'h00, 8'h40, 8'h13, 8'h05};
    send_all();
    settle();
    check("maxlen_err", err, 1'b0);
    check("maxlen_busy", busy, 1'b1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_cpu_rst", cpu_rst, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_we", imem_we, 1'b0);
    check("midrst_addr", imem_a, '0);
    check("midrst_data", imem_d, '0);
    check("midrst_err", err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tx_q = '{8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'hB0};
    send_all();
    settle();
    check("postrst_writes", wr_cnt, 8);
    check("postrst_busy", busy, 1'b0);
    check("postrst_done", done_cnt, 4);
    check("postrst_cpu_rst", cpu_rst, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_prog_loader.md
# uart_prog_loader

Serial program loader that fills the CPU's instruction memory over UART and holds the single-cycle core in reset until a verified image is present. It receives 8N1 bytes, assembles little-endian 32-bit words, and drives a synchronous write port into the instruction RAM, which is indexed by word address (PC[15:2]). It is the writer end of the instruction-fetch path: the core only reads that memory, and this block is the only writer.

## Interface
- CLKS_PER_BIT, default 217: clk cycles per UART bit; 25 MHz / 115200. Must be ≥ 8.
- ADDR_W, default 14: instruction memory word-address width.
- clk  in  1  core clock, the same clock as the CPU.
- rst  in  1  reset, asynchronous, active-high.
- uart_rx_i  in  1  serial input, idle high, asynchronous to clk.
- imem_we_o  out  1  instruction memory write enable, one-cycle pulse per word.
- imem_a_o  out  ADDR_W  word address.
- imem_d_o  out  32  write data.
- cpu_rst_o  out  1  CPU hold-in-reset, active-high.
- busy_o  out  1  high while a frame is being loaded.
- done_o  out  1  one-cycle pulse on a successful load.
- err_o  out  1  sticky error flag.

## Operation
- RX front end:
  - 2-flop synchronizer on uart_rx_i.
  - A falling edge starts a bit counter.
  - The start bit is re-checked at CLKS_PER_BIT/2. If it is high there, the event is a glitch: return to idle with no error.
  - Data bits are sampled mid-bit, LSB first, then the stop bit.
  - Stop bit = 1: one-cycle internal byte_valid with the byte.
  - Stop bit = 0: framing error.
- Frame format:
  - Sync byte 0xA5.
  - Word count N, 16-bit little-endian.
  - N×4 data bytes, each word little-endian.
  - One checksum byte, equal to the XOR of all data bytes (sync and count bytes excluded).
- Loader FSM states: WAIT_SYNC, LEN_LO, LEN_HI, DATA, CSUM, RUN.
  - WAIT_SYNC: bytes other than 0xA5 are ignored. 0xA5 → LEN_LO; clears err_o, the checksum and the word index.
  - LEN_LO → LEN_HI on the next byte.
  - LEN_HI: N > 2^ADDR_W → set err_o, go to WAIT_SYNC. N = 0 → CSUM. Otherwise → DATA.
  - DATA: bytes are shifted into a 4-byte assembler.
    - On the 4th byte, write the word at the current index, then increment the index.
    - After word N-1 → CSUM.
  - CSUM: match → RUN, done_o pulse, cpu_rst_o deasserts. Mismatch → set err_o, go to WAIT_SYNC.
  - RUN: image loaded. Receiving 0xA5 starts a reload: cpu_rst_o reasserts, go to LEN_LO.
- A framing error in any state except RUN sets err_o, aborts to WAIT_SYNC, and keeps cpu_rst_o high. Words already written stay in memory.
- A framing error in RUN is ignored.
- cpu_rst_o is high in every state except RUN.
- busy_o is high in LEN_LO, LEN_HI, DATA and CSUM.

## Timing
- Reset values:
  - cpu_rst_o = 1; all other outputs = 0.
  - imem_a_o and imem_d_o = 0.
  - FSM = WAIT_SYNC.
- Reset is asynchronous. Asserting it mid-load immediately drops imem_we_o and returns to WAIT_SYNC; no partial word is written after reset.
- byte_valid fires in the cycle after the mid-stop-bit sample.
- For the 4th byte of a word, imem_we_o is high in the cycle after byte_valid. imem_a_o and imem_d_o are valid and stable in that same cycle.
- The index increments after the write, so word k is written at address k.
- On a checksum match, done_o pulses in the cycle after the checksum byte_valid. cpu_rst_o goes low in that same cycle and stays low while in RUN.
- In RUN, cpu_rst_o goes high in the cycle after a 0xA5 byte_valid.
- err_o is set in the cycle after the detecting event. It holds until the next accepted sync byte or reset.
- Timing is a single clock domain. Beyond the synchronizer there is no handshake with the memory: a write completes in one cycle.

## Test plan
- Reset → cpu_rst_o=1, busy_o=0, done_o=0, err_o=0, imem_we_o=0. Idle line for 1000 cycles → no change.
- Send 0x00 0x5A (garbage), then A5 02 00 13 05 10 00 93 05 20 00 B0 → exactly two writes: addr 0 = 0x00100513, addr 1 = 0x00200593. Then one done_o pulse, cpu_rst_o=0.
- Same frame with checksum 0xB1 → both words written, err_o=1, cpu_rst_o stays 1, no done_o. Then resend the good frame → err_o clears on A5, done_o pulses.
- Stop bit forced 0 on the 3rd data byte → err_o=1, no write, FSM back in WAIT_SYNC. Then a good frame loads normally.
- A5 00 00 00 → no writes, done_o pulse. A5 01 40 → (N = 0x4001 > 16384) err_o=1, no writes.
- Assert rst while in DATA after 2 bytes of word 0 → outputs immediately at reset values, and no write occurs for the remaining bytes.
- From RUN, send A5 → cpu_rst_o returns to 1 one cycle after that byte.
